noc_local_injector: RTL and testbench

NOC_LOCAL_INJECTOR -- requirements
Module: noc_local_injector

---
 rtl/noc_local_injector_if.sv | 37 +++
 rtl/noc_local_injector.sv | 182 ++++++++++++++++++
 tb/tb_noc_local_injector.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_local_injector_if.sv
// Shared NoC constants and the flit interface between a local injector and a
// router input port.
//
// noc_pkg             : default virtual-channel count and flit width.
// Noc_flit_interface  : one flit lane (Flit_Num = 1) shared by all VCs.
//   valid[Channel]    sender -> receiver, one-hot per VC, flit present
//   ready[Channel]    receiver -> sender, per-VC flit acceptance
//   vc_ready[Channel] receiver -> sender, VC free to start a new packet
//   flit[Flit_Num]    sender -> receiver, flit payload
//   is_header/is_tail sender -> receiver, packet framing flags
package noc_pkg;
  parameter int Noc_VC_Channel = 4;
  parameter int Noc_Data_Width = 32;
endpackage

interface Noc_flit_interface #(
  parameter int Channel    = noc_pkg::Noc_VC_Channel,
  parameter int Data_width = noc_pkg::Noc_Data_Width,
  parameter int Flit_Num   = 1
);
  logic [Channel-1:0]    valid;
  logic [Channel-1:0]    ready;
  logic [Channel-1:0]    vc_ready;
  logic [Data_width-1:0] flit      [Flit_Num];
  logic                  is_header [Flit_Num];
  logic                  is_tail   [Flit_Num];

  modport sender (
    output valid, flit, is_header, is_tail,
    input  ready, vc_ready
  );

  modport receiver (
    input  valid, flit, is_header, is_tail,
    output ready, vc_ready
  );
endinterface

// File: rtl/noc_local_injector.sv
// Local packet injector: takes a flit stream from a local source, allocates a
// virtual channel round-robin among the free ones, frames the stream into
// packets (header on first flit, tail on src_last or after Max_Len flits) and
// drives it into the NoC through a single output register.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   src_valid   source flit present
//   src_ready   source flit accepted this cycle
//   src_data    source flit payload
//   src_last    source flit closes the packet
//   noc         Noc_flit_interface sender side (Flit_Num = 1)
//   busy        a packet is being sent (SEND state)
module noc_local_injector #(
  parameter int Channel    = noc_pkg::Noc_VC_Channel,
  parameter int Data_width = noc_pkg::Noc_Data_Width,
  parameter int Max_Len    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [Data_width-1:0] src_data,
  input  logic                  src_last,
  Noc_flit_interface.sender     noc,
  output logic                  busy
);

  localparam int Vc_w  = (Channel > 1) ? $clog2(Channel) : 1;
  localparam int Cnt_w = $clog2(Max_Len) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_reg, state_next;
  logic [Vc_w-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [Vc_w-1:0]       sel_vc_reg, sel_vc_next;
  logic                  out_v_reg, out_v_next;
  logic [Data_width-1:0] out_data_reg, out_data_next;
  logic                  out_hdr_reg, out_hdr_next;
  logic                  out_tail_reg, out_tail_next;
  logic [Cnt_w-1:0]      flit_cnt_reg, flit_cnt_next;
  logic                  tail_loaded_reg, tail_loaded_next;

  // ---------------------------------------------------------------------
  // Round-robin VC search. vc_ready is rotated so that bit 0 of vc_rot is
  // the VC at rr_ptr; the lowest set bit of vc_rot is the offset of the
  // winner from rr_ptr.
  // ---------------------------------------------------------------------
  logic [2*Channel-1:0] vc_double;
  logic [Channel-1:0]   vc_rot;
  logic [Vc_w-1:0]      grant_off;
  logic                 grant_found;
  logic [Vc_w:0]        grant_sum;
  logic [Vc_w:0]        grant_wrapped;
  logic [Vc_w-1:0]      grant_vc;
  logic [Vc_w:0]        ptr_sum;
  logic [Vc_w-1:0]      ptr_after;

  assign vc_double = {noc.vc_ready, noc.vc_ready};
  assign vc_rot    = vc_double[rr_ptr_reg +: Channel];

  always_comb begin
    grant_off = '0;
    for (int k = Channel - 1; k >= 0; k--) begin
      if (vc_rot[k]) begin
        grant_off = Vc_w'(k);
      end
    end
  end

  assign grant_found   = |vc_rot;
  assign grant_sum     = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
  // Both operands are below Channel, so one conditional subtract is a full modulo.
  assign grant_wrapped = (grant_sum >= (Vc_w+1)'(Channel)) ? grant_sum - (Vc_w+1)'(Channel) : grant_sum;
  assign grant_vc      = grant_wrapped[Vc_w-1:0];
  assign ptr_sum       = {1'b0, grant_vc} + (Vc_w+1)'(1);
  assign ptr_after     = (ptr_sum == (Vc_w+1)'(Channel)) ? '0 : ptr_sum[Vc_w-1:0];

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  logic out_ready;
  logic load;
  logic xfer;
  logic load_is_tail;

  assign out_ready    = noc.ready[sel_vc_reg];
  assign xfer         = out_v_reg & out_ready;
  // Once the tail sits in the output register nothing more is accepted, so a
  // following packet must go back through allocation.
  assign src_ready    = (state_reg == SEND) & ~tail_loaded_reg & (~out_v_reg | out_ready);
  assign load         = src_valid & src_ready;
  assign load_is_tail = src_last | (flit_cnt_reg == Cnt_w'(Max_Len - 1));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    sel_vc_next      = sel_vc_reg;
    out_v_next       = out_v_reg;
    out_data_next    = out_data_reg;
    out_hdr_next     = out_hdr_reg;
    out_tail_next    = out_tail_reg;
    flit_cnt_next    = flit_cnt_reg;
    tail_loaded_next = tail_loaded_reg;

    case (state_reg)
      IDLE: begin
        if (src_valid && grant_found) begin
          state_next       = SEND;
          sel_vc_next      = grant_vc;
          rr_ptr_next      = ptr_after;
          flit_cnt_next    = '0;
          tail_loaded_next = 1'b0;
        end
      end
      SEND: begin
        if (xfer && out_tail_reg) begin
          state_next       = IDLE;
          out_v_next       = 1'b0;
          tail_loaded_next = 1'b0;
        end else begin
          if (xfer) begin
            out_v_next = 1'b0;
          end
          if (load) begin
            out_v_next    = 1'b1;
            out_data_next = src_data;
            out_hdr_next  = (flit_cnt_reg == '0);
            out_tail_next = load_is_tail;
            flit_cnt_next = flit_cnt_reg + Cnt_w'(1);
            if (load_is_tail) begin
              tail_loaded_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      sel_vc_reg      <= '0;
      out_v_reg       <= 1'b0;
      out_data_reg    <= '0;
      out_hdr_reg     <= 1'b0;
      out_tail_reg    <= 1'b0;
      flit_cnt_reg    <= '0;
      tail_loaded_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      sel_vc_reg      <= sel_vc_next;
      out_v_reg       <= out_v_next;
      out_data_reg    <= out_data_next;
      out_hdr_reg     <= out_hdr_next;
      out_tail_reg    <= out_tail_next;
      flit_cnt_reg    <= flit_cnt_next;
      tail_loaded_reg <= tail_loaded_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: the single output lane is steered onto the allocated VC only.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < Channel; gi++) begin : g_valid
    assign noc.valid[gi] = out_v_reg & (sel_vc_reg == Vc_w'(gi));
  end

  assign noc.flit[0]      = out_data_reg;
  assign noc.is_header[0] = out_hdr_reg;
  assign noc.is_tail[0]   = out_tail_reg;
  assign busy             = (state_reg == SEND);

endmodule

// File: tb/tb_noc_local_injector.sv
module tb_noc_local_injector;
  localparam int CH = 4;
  localparam int DW = 16;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          busy;

  Noc_flit_interface #(.Channel(CH), .Data_width(DW), .Flit_Num(1)) noc ();

  noc_local_injector #(.Channel(CH), .Data_width(DW), .Max_Len(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_last  (src_last),
    .noc       (noc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  bit abort = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (packet level) ----------------
  bit            m_busy = 0;   // a packet owns a VC
  bit            m_hold = 0;   // a flit is waiting at the output
  bit            m_hdr = 0, m_tail = 0;
  bit            m_closed = 0; // packet's last flit already taken from source
  int            m_ptr = 0, m_vc = 0, m_count = 0;
  logic [DW-1:0] m_data = '0;

  typedef struct {int cyc; int vc; int data; bit hdr; bit tail;} xfer_t;
  xfer_t xlog[$];
  int    sb[$];

  always @(negedge clk) begin
    bit            exp_rdy, acc, xfer, found;
    logic [CH-1:0] exp_val;
    int            pick, vcx;
    xfer_t         e;
    exp_rdy = m_busy && !m_closed && (!m_hold || noc.ready[m_vc]);
    exp_val = m_hold ? CH'(1 << m_vc) : '0;
    chk("src_ready", src_ready, exp_rdy);
    chk("valid", noc.valid, exp_val);
    chk("busy", busy, m_busy);
    if (m_hold) begin
      chk("flit", noc.flit[0], m_data);
      chk("is_header", noc.is_header[0], m_hdr);
      chk("is_tail", noc.is_tail[0], m_tail);
    end
    // transaction log and in-order scoreboard built from the DUT's pins
    if (!rst) begin
      if (src_valid && src_ready) sb.push_back(int'(src_data));
      if ((noc.valid & noc.ready) != '0) begin
        vcx = -1;
        for (int v = 0; v < CH; v++) if (noc.valid[v]) vcx = v;
        e.cyc = cyc_cnt; e.vc = vcx; e.data = int'(noc.flit[0]);
        e.hdr = noc.is_header[0]; e.tail = noc.is_tail[0];
        xlog.push_back(e);
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) chk("sb_order", e.data, sb.pop_front());
      end
    end else begin
      sb.delete();
    end
    // advance the model across the coming edge
    acc  = src_valid && exp_rdy;
    xfer = m_hold && noc.ready[m_vc];
    if (rst) begin
      m_busy = 0; m_hold = 0; m_hdr = 0; m_tail = 0; m_closed = 0;
      m_ptr = 0; m_vc = 0; m_count = 0; m_data = '0;
    end else if (!m_busy) begin
      found = 0; pick = 0;
      for (int k = 0; k < CH; k++) begin
        if (!found && noc.vc_ready[(m_ptr + k) % CH]) begin
          found = 1; pick = (m_ptr + k) % CH;
        end
      end
      if (src_valid && found) begin
        m_busy = 1; m_vc = pick; m_ptr = (pick + 1) % CH;
        m_count = 0; m_closed = 0;
      end
    end else if (xfer && m_tail) begin
      m_busy = 0; m_hold = 0; m_closed = 0;
    end else if (acc) begin
      m_hold = 1; m_data = src_data;
      m_hdr = (m_count == 0);
      m_tail = src_last || (m_count == ML - 1);
      m_count++;
      if (m_tail) m_closed = 1;
    end else if (xfer) begin
      m_hold = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; src_valid = 0; src_last = 0; abort = 0;
    cyc(); cyc();
    rst = 0;
    xlog.delete();
  endtask

  function automatic bit is_last(input int i, input int n, input int pkt);
    return (i == n - 1) || (pkt > 0 && ((i + 1) % pkt) == 0);
  endfunction

  // Presents n flits (data base+i) honouring src_ready; pkt>0 marks src_last
  // every pkt flits, otherwise only on the final flit.
  task automatic stream(input int n, input int pkt, input int base);
    int i; int budget; bit acc;
    i = 0; budget = 300;
    src_valid = 1; src_data = DW'(base); src_last = is_last(0, n, pkt);
    while (i < n && !abort && budget > 0) begin
      @(negedge clk); acc = src_ready && !rst;
      cyc(); budget--;
      if (acc) begin
        i++;
        if (i < n) begin
          src_data = DW'(base + i); src_last = is_last(i, n, pkt);
        end else src_valid = 0;
      end
    end
    src_valid = 0; src_last = 0;
    chk("stream_budget", (budget > 0), 1);
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    while ((busy || noc.valid != '0) && budget > 0) begin cyc(); budget--; end
    chk("drain_budget", (budget > 0), 1);
  endtask

  task automatic wait_log(input int k);
    int budget;
    budget = 100;
    while (xlog.size() < k && budget > 0) begin cyc(); budget--; end
    chk("wait_log_budget", (budget > 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst = 1; src_valid = 0; src_data = '0; src_last = 0;
    noc.ready = '0; noc.vc_ready = '0;
    repeat (3) cyc();
    chk("rst_valid", noc.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src_ready", src_ready, 0);
    rst = 0;

    // single-flit packet, vc_ready=0110 from rr_ptr 0
    noc.vc_ready = 4'b0110; noc.ready = '1;
    src_valid = 1; src_data = 16'h00A5; src_last = 1;
    cyc();
    chk("t1_busy", busy, 1);
    chk("t1_src_ready", src_ready, 1);
    chk("t1_valid_early", noc.valid, 0);
    cyc(); src_valid = 0; src_last = 0;
    chk("t1_valid", noc.valid, 4'b0010);
    chk("t1_data", noc.flit[0], 16'h00A5);
    chk("t1_hdr", noc.is_header[0], 1);
    chk("t1_tail", noc.is_tail[0], 1);
    chk("t1_model_vc", m_vc, 1);
    cyc();
    chk("t1_idle", busy, 0);
    chk("t1_model_ptr", m_ptr, 2);

    // back-to-back 3-flit packets
    do_reset();
    noc.vc_ready = 4'b1111; noc.ready = '1;
    stream(6, 3, 16'h100);
    drain();
    chk("b2b_count", xlog.size(), 6);
    if (xlog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("b2b_data", xlog[i].data, 16'h100 + i);
        chk("b2b_vc", xlog[i].vc, i / 3);
        chk("b2b_hdr", xlog[i].hdr, (i % 3) == 0);
        chk("b2b_tail", xlog[i].tail, (i % 3) == 2);
      end
      chk("b2b_gap01", xlog[1].cyc - xlog[0].cyc, 1);
      chk("b2b_gap12", xlog[2].cyc - xlog[1].cyc, 1);
      chk("b2b_gap23", xlog[3].cyc - xlog[2].cyc, 3);
    end

    // backpressure mid-packet
    do_reset();
    noc.vc_ready = 4'b1111; noc.ready = '1;
    fork
      stream(3, 3, 16'h200);
      begin
        wait_log(1);
        noc.ready = '0;
        cyc();
        chk("bp_src_ready", src_ready, 0);
        chk("bp_valid_held", noc.valid, 4'b0001);
        chk("bp_data_held", noc.flit[0], 16'h201);
        cyc(); cyc();
        noc.ready = '1;
      end
    join
    drain();
    chk("bp_count", xlog.size(), 3);
    if (xlog.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("bp_data", xlog[i].data, 16'h200 + i);
      chk("bp_gap", xlog[1].cyc - xlog[0].cyc, 4);
      chk("bp_tail", xlog[2].tail, 1);
    end

    // forced split at Max_Len
    do_reset();
    noc.vc_ready = 4'b1111; noc.ready = '1;
    stream(6, 0, 16'h300);
    drain();
    chk("split_count", xlog.size(), 6);
    if (xlog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("split_data", xlog[i].data, 16'h300 + i);
        chk("split_vc", xlog[i].vc, (i < 4) ? 0 : 1);
        chk("split_hdr", xlog[i].hdr, (i == 0 || i == 4));
        chk("split_tail", xlog[i].tail, (i == 3 || i == 5));
      end
    end

    // pointer wrap and no free VC
    do_reset();
    noc.ready = '1; noc.vc_ready = 4'b0100;
    stream(1, 0, 16'h400);
    drain();
    chk("wrap_model_ptr3", m_ptr, 3);
    noc.vc_ready = 4'b0001;
    stream(1, 0, 16'h401);
    drain();
    chk("wrap_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("wrap_vc_first", xlog[0].vc, 2);
      chk("wrap_vc", xlog[1].vc, 0);
    end
    chk("wrap_model_ptr1", m_ptr, 1);
    noc.vc_ready = '0; src_valid = 1; src_data = 16'h402; src_last = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("novc_busy", busy, 0);
      chk("novc_src_ready", src_ready, 0);
    end
    src_valid = 0; src_last = 0;

    // reset in the middle of a packet
    do_reset();
    noc.vc_ready = 4'b1111; noc.ready = '1;
    fork
      stream(5, 0, 16'h500);
      begin
        wait_log(2);
        rst = 1; abort = 1; src_valid = 0;
        cyc();
        chk("midrst_valid", noc.valid, 0);
        chk("midrst_busy", busy, 0);
        rst = 0;
      end
    join
    abort = 0;
    xlog.delete();
    stream(2, 0, 16'h600);
    drain();
    chk("postrst_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("postrst_hdr", xlog[0].hdr, 1);
      chk("postrst_vc", xlog[0].vc, 0);
      chk("postrst_data", xlog[0].data, 16'h600);
      chk("postrst_tail", xlog[1].tail, 1);
    end

    // randomized traffic, checked cycle by cycle against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); acc = src_valid && src_ready && !rst;
      cyc();
      noc.ready    = CH'($urandom);
      noc.vc_ready = CH'($urandom);
      rst          = (($urandom % 300) == 0);
      if (!src_valid || acc) begin
        src_valid = (($urandom % 4) != 0);
        src_data  = DW'($urandom);
        src_last  = (($urandom % 3) == 0);
      end
    end
    do_reset();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
